// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared cacheline memory port between the I-side and D-side caches.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between sides instead of D always winning.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-side (fetch) cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-side (load/store) cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // burst-memory adapter
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                d_pending;
  logic                d_wins_tie;
  logic                serving;

  assign d_pending = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  owner_e last_grant_q, last_grant_d;

  // D takes a tie only if I was the side served most recently.
  assign d_wins_tie = (last_grant_q == OWNER_I);

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWNER_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign d_wins_tie = 1'b1;
`endif

  // Next-state and grant capture.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_pending && (!i_read || d_wins_tie)) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          write_d = d_write;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = OWNER_D;
`endif
        end else if (i_read) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          wdata_d = '0;
          write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = OWNER_I;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Memory strobes come only from registered state, never from requester inputs.
  assign serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign mem_read  = serving && !write_q;
  assign mem_write = serving && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_rdata = (state_q == SERVE_I) ? mem_rdata : '0;
  assign d_rdata = (state_q == SERVE_D) ? mem_rdata : '0;

  // A simultaneous D read and write is a requester bug; the write wins above.
  a_no_d_read_and_write : assert property (
    @(posedge clk) disable iff (rst) !(d_read && d_write)
  );

endmodule
